// File: rtl/dma_pkg.sv
// ---------------------------------------------------------------------------
// dma_pkg
// Shared constants and types for the DMA line path. The line FIFO and the
// DMA state machine both import this so that line width and the number of
// bus words per line stay in agreement.
//   CL_SIZE_WIDTH : cache-line width in bits
//   WORD_SIZE     : DMA bus word width in bits
//   line_t        : one cache line
//   FILL_COUNT    : bus words needed to fill one line
// ---------------------------------------------------------------------------
package dma_pkg;

  localparam int CL_SIZE_WIDTH = 512;
  localparam int WORD_SIZE     = 32;
  localparam int FILL_COUNT    = CL_SIZE_WIDTH / WORD_SIZE;

  typedef logic [CL_SIZE_WIDTH-1:0] line_t;

endpackage

// File: rtl/dma_line_fifo_if.sv
// ---------------------------------------------------------------------------
// dma_line_fifo_if
// Handshake bundle between the host-side producer, the DMA-side consumer and
// the line FIFO.
//   master : the side that pushes/pops (drives wr_en, wr_data, rd_en)
//   slave  : the FIFO itself (drives data and status back)
// Signals:
//   wr_en/wr_data      push request and line
//   rd_en              pop request
//   rd_data            show-ahead head line (zero while empty)
//   full/almost_full   registered fill status
//   empty/count        registered occupancy status
//   overflow/underflow sticky rejected-access flags
// ---------------------------------------------------------------------------
interface dma_line_fifo_if #(
  parameter int CL_SIZE_WIDTH = dma_pkg::CL_SIZE_WIDTH,
  parameter int DEPTH         = 4
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                     wr_en;
  logic [CL_SIZE_WIDTH-1:0] wr_data;
  logic                     full;
  logic                     almost_full;
  logic                     rd_en;
  logic [CL_SIZE_WIDTH-1:0] rd_data;
  logic                     empty;
  logic [CNT_W-1:0]         count;
  logic                     overflow;
  logic                     underflow;

  modport master (
    output wr_en, wr_data, rd_en,
    input  full, almost_full, rd_data, empty, count, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
    output full, almost_full, rd_data, empty, count, overflow, underflow
  );

endinterface

// File: rtl/dma_line_ram.sv
// ---------------------------------------------------------------------------
// dma_line_ram
// DEPTH x WIDTH line storage: one synchronous write port, one asynchronous
// read port. No reset -- contents are only meaningful where the FIFO control
// logic says an entry is valid.
// Ports:
//   clk    clock
//   we     write enable (already qualified by the FIFO)
//   waddr  write address
//   wdata  write line
//   raddr  read address
//   rdata  line at raddr, combinational
// ---------------------------------------------------------------------------
module dma_line_ram #(
  parameter int WIDTH = dma_pkg::CL_SIZE_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dma_line_fifo.sv
// ---------------------------------------------------------------------------
// dma_line_fifo
// Show-ahead circular line buffer between the host (producer) and the DMA
// engine (consumer).
// Parameters:
//   CL_SIZE_WIDTH  line width in bits
//   DEPTH          number of line entries (power of two, >= 2)
//   AF_LEVEL       occupancy at or above which almost_full asserts
// Ports:
//   clk            clock, all state on rising edge
//   rst            asynchronous active-high reset (control state only)
//   bus            dma_line_fifo_if.slave handshake/status bundle
// ---------------------------------------------------------------------------
module dma_line_fifo #(
  parameter int CL_SIZE_WIDTH = dma_pkg::CL_SIZE_WIDTH,
  parameter int DEPTH         = 4,
  parameter int AF_LEVEL      = DEPTH - 1
) (
  input  logic           clk,
  input  logic           rst,
  dma_line_fifo_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]         wr_ptr;
  logic [PTR_W-1:0]         rd_ptr;
  logic [CNT_W-1:0]         count_q;
  logic [CNT_W-1:0]         count_nxt;
  logic                     full_q;
  logic                     empty_q;
  logic                     af_q;
  logic                     ovf_q;
  logic                     udf_q;
  logic                     push;
  logic                     pop;
  logic [CL_SIZE_WIDTH-1:0] ram_rdata;

  // Acceptance is decided by the registered flags only, so a pop in the
  // same cycle never frees room for a push to a full FIFO (and vice versa).
  assign push = bus.wr_en & ~full_q;
  assign pop  = bus.rd_en & ~empty_q;

  always_comb begin
    count_nxt = count_q;
    unique case ({push, pop})
      2'b10:   count_nxt = count_q + CNT_W'(1);
      2'b01:   count_nxt = count_q - CNT_W'(1);
      default: count_nxt = count_q;
    endcase
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count_q <= count_nxt;
      full_q  <= (count_nxt == CNT_W'(DEPTH));
      empty_q <= (count_nxt == '0);
      af_q    <= (count_nxt >= CNT_W'(AF_LEVEL));
      if (bus.wr_en && full_q) begin
        ovf_q <= 1'b1;
      end
      if (bus.rd_en && empty_q) begin
        udf_q <= 1'b1;
      end
    end
  end

  dma_line_ram #(
    .WIDTH (CL_SIZE_WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (bus.wr_data),
    .raddr (rd_ptr),
    .rdata (ram_rdata)
  );

  // Storage is never cleared, so stale lines are masked while empty; this
  // also makes rd_data zero as soon as reset asserts.
  assign bus.rd_data     = empty_q ? '0 : ram_rdata;
  assign bus.full        = full_q;
  assign bus.empty       = empty_q;
  assign bus.almost_full = af_q;
  assign bus.count       = count_q;
  assign bus.overflow    = ovf_q;
  assign bus.underflow   = udf_q;

endmodule

// File: doc/dma_line_fifo.md
DMA_LINE_FIFO -- requirements
Module: dma_line_fifo

Interface
REQ-001 Parameter CL_SIZE_WIDTH, default 512, cache-line width in bits.
REQ-002 Parameter DEPTH, default 4, line entries; power of two, at least 2.
REQ-003 Parameter AF_LEVEL, default DEPTH-1, occupancy at or above which almost_full asserts.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 wr_en  input  1  host-side push request.
REQ-007 wr_data  input  CL_SIZE_WIDTH  line to push.
REQ-008 full  output  1  no free entry.
REQ-009 almost_full  output  1  count at or above AF_LEVEL.
REQ-010 rd_en  input  1  DMA-side pop request (the DMA engine's read-enable).
REQ-011 rd_data  output  CL_SIZE_WIDTH  head line, show-ahead.
REQ-012 empty  output  1  no valid entry.
REQ-013 count  output  $clog2(DEPTH)+1  current occupancy.
REQ-014 overflow  output  1  sticky: a write was rejected.
REQ-015 underflow  output  1  sticky: a read was rejected.

Function
REQ-016 The FIFO SHALL be a circular buffer with write and read pointers, each $clog2(DEPTH) bits, wrapping from DEPTH-1 to 0.
REQ-017 A push SHALL be accepted iff wr_en=1 and the registered full=0; the line is stored at the write pointer and the pointer increments.
REQ-018 A pop SHALL be accepted iff rd_en=1 and the registered empty=0; the read pointer increments.
REQ-019 rd_data SHALL combinationally equal the entry at the read pointer when empty=0, and all-zero when empty=1.
REQ-020 An accepted push SHALL deassert empty, update count, and make the line visible on rd_data in the cycle after the push edge (one-cycle write-to-read latency).
REQ-021 An accepted push and pop in the same cycle SHALL leave count, full and empty unchanged and advance both pointers.
REQ-022 wr_en=1 while full=1 SHALL be dropped and set overflow, even if rd_en=1 in that cycle.
REQ-023 rd_en=1 while empty=1 SHALL be ignored and set underflow, even if wr_en=1 in that cycle; the write is still accepted.
REQ-024 full, empty, almost_full and count SHALL be registered and computed from the next occupancy.
REQ-025 overflow and underflow SHALL remain set until reset.
REQ-026 Stored data SHALL not change on a rejected write.

Reset
REQ-027 While rst=1, pointers and count SHALL be 0, empty=1, full=0, almost_full=0, overflow=0, underflow=0, and rd_data=0.
REQ-028 Reset asserted mid-operation SHALL discard all entries immediately; the storage array is not cleared.
REQ-029 The first push SHALL be accepted on the first rising edge after rst deasserts.

Structure
REQ-030 Package dma_pkg SHALL hold CL_SIZE_WIDTH, WORD_SIZE (32), typedef line_t (CL_SIZE_WIDTH bits) and FILL_COUNT = CL_SIZE_WIDTH/WORD_SIZE, shared with the DMA state machine.
REQ-031 Storage SHALL be a sub-module dma_line_ram: DEPTH x CL_SIZE_WIDTH, one synchronous write port and one asynchronous read port, with no reset.
REQ-032 Pointer, count, flag and error logic SHALL reside in dma_line_fifo.

Verification
REQ-033 Reset, then push lines A1..A4 (DEPTH=4) on consecutive cycles -> full=1 and count=4 after the 4th edge; empty=0 from the cycle after the first push; rd_data=A1.
REQ-034 From full, push B with rd_en=1 -> B is dropped, overflow=1, A1 is popped, count=3, and the next rd_data is A2.
REQ-035 Pop 3 more lines -> rd_data sequence A2, A3, A4, then empty=1 and rd_data=0; a further rd_en -> underflow=1 and count stays 0.
REQ-036 Continuous simultaneous push/pop for 10 cycles starting at count=2 -> count stays 2 throughout, pointers wrap, and output order matches input order.
REQ-037 With count=3, assert rst for one cycle mid-stream -> count=0, empty=1 and flags cleared immediately; a push on the next edge is readable the cycle after.
REQ-038 With AF_LEVEL=3, fill to 3 -> almost_full=1 and full=0; pop 1 -> almost_full=0.
